// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: requester handshakes plus the shared memory port
interface mem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DWIDTH     = 16
);
  logic                  i_f_req, i_d_req, i_x_req;
  logic                  i_f_we, i_d_we, i_x_we;
  logic [ADDR_WIDTH-1:0] i_f_addr, i_d_addr, i_x_addr;
  logic [DWIDTH-1:0]     i_f_wdata, i_d_wdata, i_x_wdata;
  logic                  o_f_gnt, o_d_gnt, o_x_gnt;
  logic                  o_f_rvalid, o_d_rvalid, o_x_rvalid;
  logic [DWIDTH-1:0]     o_rdata;
  logic [ADDR_WIDTH-1:0] o_mem_addr;
  logic                  o_mem_we;
  logic                  o_mem_ce;
  logic [DWIDTH-1:0]     o_mem_wdata;
  logic [DWIDTH-1:0]     i_mem_rdata;
  logic                  o_busy;
  modport slave (
    input  i_f_req, i_d_req, i_x_req, i_f_we, i_d_we, i_x_we,
           i_f_addr, i_d_addr, i_x_addr, i_f_wdata, i_d_wdata, i_x_wdata, i_mem_rdata,
    output o_f_gnt, o_d_gnt, o_x_gnt, o_f_rvalid, o_d_rvalid, o_x_rvalid,
           o_rdata, o_mem_addr, o_mem_we, o_mem_ce, o_mem_wdata, o_busy
  );
  modport master (
    output i_f_req, i_d_req, i_x_req, i_f_we, i_d_we, i_x_we,
           i_f_addr, i_d_addr, i_x_addr, i_f_wdata, i_d_wdata, i_x_wdata, i_mem_rdata,
    input  o_f_gnt, o_d_gnt, o_x_gnt, o_f_rvalid, o_d_rvalid, o_x_rvalid,
           o_rdata, o_mem_addr, o_mem_we, o_mem_ce, o_mem_wdata, o_busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin sharing of one memory port among fetch, data and I/O
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 12,
  parameter int DWIDTH     = 16,
  parameter int RD_LAT     = 1
) (
  input logic clk,
  input logic reset,
  mem_port_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  generate
    if (RD_LAT < 1 || RD_LAT > 3) begin : g_bad_lat
      $error("mem_port_arbiter: RD_LAT must be 1..3");
    end
  endgenerate
  localparam logic [1:0] CNT_INIT = 2'(RD_LAT - 1);
  state_t                r_state, w_state_nxt;
  logic [1:0]            r_last, r_win, r_cnt, w_last_nxt, w_win_nxt, w_cnt_nxt;
  logic                  r_we, w_we_nxt, w_sel_we;
  logic [ADDR_WIDTH-1:0] r_addr, w_addr_nxt, w_sel_addr;
  logic [DWIDTH-1:0]     r_wdata, w_wdata_nxt, w_sel_wdata;
  logic [2:0]            w_req, w_gnt, w_rv;
  logic [1:0]            w_p0, w_p1, w_pick;
  function automatic logic [1:0] nxt(input logic [1:0] p);
    return p == 2'd2 ? 2'd0 : p + 2'd1;
  endfunction
  assign w_req       = {bus.i_x_req, bus.i_d_req, bus.i_f_req};
  assign w_p0        = nxt(r_last);
  assign w_p1        = nxt(w_p0);
  assign w_pick      = w_req[w_p0] ? w_p0 : w_req[w_p1] ? w_p1 : r_last;
  assign w_sel_we    = w_pick == 2'd0 ? bus.i_f_we    : w_pick == 2'd1 ? bus.i_d_we    : bus.i_x_we;
  assign w_sel_addr  = w_pick == 2'd0 ? bus.i_f_addr  : w_pick == 2'd1 ? bus.i_d_addr  : bus.i_x_addr;
  assign w_sel_wdata = w_pick == 2'd0 ? bus.i_f_wdata : w_pick == 2'd1 ? bus.i_d_wdata : bus.i_x_wdata;
  assign bus.o_rdata = bus.i_mem_rdata;
  assign {bus.o_x_gnt, bus.o_d_gnt, bus.o_f_gnt}          = w_gnt;
  assign {bus.o_x_rvalid, bus.o_d_rvalid, bus.o_f_rvalid} = w_rv;
  // next-state, transaction capture and all FSM-driven outputs
  always_comb begin
    w_state_nxt     = r_state;
    w_last_nxt      = r_last;
    w_win_nxt       = r_win;
    w_we_nxt        = r_we;
    w_addr_nxt      = r_addr;
    w_wdata_nxt     = r_wdata;
    w_cnt_nxt       = r_cnt;
    w_gnt           = '0;
    w_rv            = '0;
    bus.o_mem_ce    = 1'b0;
    bus.o_mem_we    = 1'b0;
    bus.o_mem_addr  = '0;
    bus.o_mem_wdata = '0;
    bus.o_busy      = r_state != IDLE;
    case (r_state)
      IDLE: if (|w_req) begin
        w_state_nxt = ISSUE;
        w_last_nxt  = w_pick;
        w_win_nxt   = w_pick;
        w_we_nxt    = w_sel_we;
        w_addr_nxt  = w_sel_addr;
        w_wdata_nxt = w_sel_wdata;
      end
      ISSUE: begin
        w_gnt           = 3'b001 << r_win;
        bus.o_mem_ce    = 1'b1;
        bus.o_mem_we    = r_we;
        bus.o_mem_addr  = r_addr;
        bus.o_mem_wdata = r_wdata;
        w_state_nxt     = r_we ? IDLE : WAIT;
        w_cnt_nxt       = r_we ? r_cnt : CNT_INIT;
      end
      WAIT: if (r_cnt == 2'd0) begin
        w_rv        = 3'b001 << r_win;
        w_state_nxt = IDLE;
      end else begin
        w_cnt_nxt = r_cnt - 2'd1;
      end
      default: w_state_nxt = IDLE;
    endcase
  end
  // state register; reset drops any in-flight read and points rr at x so f goes first
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_last  <= 2'd2;
      r_win   <= 2'd0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_cnt   <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      r_last  <= w_last_nxt;
      r_win   <= w_win_nxt;
      r_we    <= w_we_nxt;
      r_addr  <= w_addr_nxt;
      r_wdata <= w_wdata_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end
endmodule
